// File: rtl/alu_ops_pkg.sv
// Shared ALU operation package: opcodes on the 6-bit Signal bus (shared with
// the MULTU multiplier), the multi-cycle unit state enum and the default width.
package alu_ops_pkg;

  // Default operand width for multi-cycle ALU units
  localparam int DIV_WIDTH_DEF = 32;

  // Opcodes carried on the shared Signal bus
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_OUT   = 6'b111111;

  // Multi-cycle unit sequencing state
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/divider_step.sv
// One restoring shift-subtract iteration, purely combinational.
// The partial remainder is shifted left taking in the dividend MSB still held
// at the top of the quotient register; the compare is WIDTH+1 bits wide
// because the shifted remainder can exceed WIDTH bits when the divisor has
// its top bit set.
module divider_step
  import alu_ops_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quot
);

  logic [WIDTH:0] rem_shift;
  logic           take;

  // Shift, trial-compare, and conditionally subtract
  always_comb begin
    rem_shift = {rem, quot[WIDTH-1]};
    take      = (rem_shift >= {1'b0, divisor});
    // Truncated subtraction is exact: when take is set the difference fits in
    // WIDTH bits because the previous remainder was below the divisor.
    next_rem  = take ? (rem_shift[WIDTH-1:0] - divisor) : rem_shift[WIDTH-1:0];
    next_quot = {quot[WIDTH-2:0], take};
  end

endmodule

// File: rtl/divider.sv
// Multi-cycle 32/32 restoring divider sharing the ALU Signal opcode bus.
// DIVU starts a divide (one quotient bit per clock, WIDTH cycles), OUT
// publishes the internal {remainder, quotient} result register on dataOut.
// Optional macro DIVIDER_SIGNED_EN adds the signed DIV opcode (truncating
// division, sign fix-up in the final iteration cycle).
//
// Handshake: there is no valid/ready pair; an opcode is accepted only when the
// unit is IDLE on the clock edge it is presented. DIVU/DIV/OUT seen while RUN
// (including the edge that writes the result) are dropped. busy is high from
// the accepting edge until the final-step edge; done pulses for the one cycle
// after the result register is written.
// state_dbg exposes the FSM state for checkers.
// CNT_W must satisfy 2**CNT_W > WIDTH so the counter can hold WIDTH.
module divider
  import alu_ops_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Signal,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic [2*WIDTH-1:0] dataOut,
  output logic               busy,
  output logic               done,
  output state_e             state_dbg
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   divisor;
  logic [2*WIDTH-1:0] result;

  // Acceptance decode and operand conditioning
  logic               start;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;

  // Iteration outputs and final (sign-fixed) result
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quot;
  logic [WIDTH-1:0]   fin_rem;
  logic [WIDTH-1:0]   fin_quot;
  logic               last_step;

`ifdef DIVIDER_SIGNED_EN
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic               neg_q_in;
  logic               neg_r_in;
  logic               div_zero_in;
`endif

  assign state_dbg = state;
  assign last_step = (cnt == CNT_W'(1));

  // Single restoring iteration shared by every RUN cycle
  divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem       (rem),
    .quot      (quot),
    .divisor   (divisor),
    .next_rem  (step_rem),
    .next_quot (step_quot)
  );

  // Decode an accepted start and form the operands the datapath will divide
  always_comb begin
    start = (state == IDLE) && (Signal == OP_DIVU);
    a_in  = dataA;
    b_in  = dataB;
`ifdef DIVIDER_SIGNED_EN
    neg_q_in    = 1'b0;
    neg_r_in    = 1'b0;
    div_zero_in = (dataB == '0);
    if ((state == IDLE) && (Signal == OP_DIV)) begin
      start    = 1'b1;
      a_in     = dataA[WIDTH-1] ? (-dataA) : dataA;
      b_in     = dataB[WIDTH-1] ? (-dataB) : dataB;
      neg_q_in = dataA[WIDTH-1] ^ dataB[WIDTH-1];
      neg_r_in = dataA[WIDTH-1];
    end
`endif
  end

  // Result fix-up applied on the final iteration cycle
  always_comb begin
    fin_rem  = step_rem;
    fin_quot = step_quot;
`ifdef DIVIDER_SIGNED_EN
    // A zero divisor keeps the all-ones quotient; the remainder negation
    // still restores the original signed dividend from its magnitude.
    if (neg_q && !div_zero) fin_quot = -step_quot;
    if (neg_r)              fin_rem  = -step_rem;
`endif
  end

  // Sequencer: accept in IDLE, iterate in RUN, publish on OUT in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quot     <= '0;
      divisor  <= '0;
      result   <= '0;
      dataOut  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (Signal == OP_OUT) begin
            dataOut <= result;
          end
          if (start) begin
            quot    <= a_in;
            divisor <= b_in;
            rem     <= '0;
            cnt     <= CNT_W'(WIDTH);
            busy    <= 1'b1;
            state   <= RUN;
`ifdef DIVIDER_SIGNED_EN
            neg_q    <= neg_q_in;
            neg_r    <= neg_r_in;
            div_zero <= div_zero_in;
`endif
          end
        end
        RUN: begin
          rem  <= step_rem;
          quot <= step_quot;
          cnt  <= cnt - CNT_W'(1);
          if (last_step) begin
            result <= {fin_rem, fin_quot};
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed vector table, randomized runs
// against an arithmetic reference model, and hand-written protocol sequences
// (mid-run opcodes, OUT on the final edge, back-to-back start, reset abort).
module tb_divider;
  import alu_ops_pkg::*;

  localparam int W = 32;
  localparam logic [5:0] OP_NOP = 6'b000000;

  // Clock / reset
  logic           clk;
  logic           reset;
  logic [5:0]     Signal;
  logic [W-1:0]   dataA;
  logic [W-1:0]   dataB;
  logic [2*W-1:0] dataOut;
  logic           busy;
  logic           done;
  state_e         state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  divider #(
    .WIDTH (W),
    .CNT_W (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Signal    (Signal),
    .dataA     (dataA),
    .dataB     (dataB),
    .dataOut   (dataOut),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Scoreboard
  int             checks;
  int             errors;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_pub;

  typedef struct {
    string        name;
    logic [5:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check64(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: quotient/remainder from plain arithmetic
  function automatic logic [2*W-1:0] model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    int q;
    int r;
    if (b == 0) return {a, {W{1'b1}}};
    if (op == OP_DIV) begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
      return {r[W-1:0], q[W-1:0]};
    end
    return {a % b, a / b};
  endfunction

  // Driver tasks; all run in the phase 1ns after a rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_op(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Signal = op;
    dataA  = a;
    dataB  = b;
    tick(1);
    Signal = OP_NOP;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      tick(1);
      lat++;
    end
  endtask

  task automatic publish();
    Signal = OP_OUT;
    tick(1);
    Signal = OP_NOP;
  endtask

  task automatic run_and_check(input string name, input logic [5:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [2*W-1:0] exp);
    int lat;
    start_op(op, a, b);
    check_int({name, "_busy_start"}, int'(busy), 1);
    wait_done(lat);
    check_int({name, "_latency"}, lat, 32);
    check_int({name, "_busy_at_done"}, int'(busy), 0);
    check64({name, "_hold_at_done"}, dataOut, last_pub);
    exp_q.push_back(exp);
    publish();
    last_pub = exp_q.pop_front();
    check64(name, dataOut, last_pub);
    check_int({name, "_done_pulse"}, int'(done), 0);
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    checks   = 0;
    errors   = 0;
    last_pub = '0;
    reset    = 1'b1;
    Signal   = OP_NOP;
    dataA    = '0;
    dataB    = '0;
    tick(3);
    reset = 1'b0;

    // Reset state
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    check64("reset_dataOut", dataOut, '0);
    check_int("reset_state", int'(state_dbg), int'(IDLE));

    // Directed vector table
    vecs.push_back('{"div_100_7",   OP_DIVU, 32'd100,        32'd7,        64'h00000002_0000000E});
    vecs.push_back('{"div_max_1",   OP_DIVU, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF});
    vecs.push_back('{"div_5_9",     OP_DIVU, 32'd5,          32'd9,        64'h00000005_00000000});
    vecs.push_back('{"div_by_zero", OP_DIVU, 32'h00001234,   32'd0,        64'h00001234_FFFFFFFF});
    vecs.push_back('{"div_big_dvs", OP_DIVU, 32'hFFFFFFFE,   32'h80000001, 64'h7FFFFFFD_00000001});
    vecs.push_back('{"div_equal",   OP_DIVU, 32'h89ABCDEF,   32'h89ABCDEF, 64'h00000000_00000001});
`ifdef DIVIDER_SIGNED_EN
    vecs.push_back('{"sdiv_m7_2",   OP_DIV,  32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD});
    vecs.push_back('{"sdiv_7_m2",   OP_DIV,  32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD});
    vecs.push_back('{"sdiv_m9_0",   OP_DIV,  32'hFFFFFFF7,   32'd0,        64'hFFFFFFF7_FFFFFFFF});
`endif
    foreach (vecs[i]) run_and_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Randomized runs against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom >> $urandom_range(0, 31));
      run_and_check("rand_divu", OP_DIVU, ra, rb, model(OP_DIVU, ra, rb));
`ifdef DIVIDER_SIGNED_EN
      ra = W'($urandom_range(0, 200000)) - W'(100000);
      rb = W'($urandom_range(0, 2000)) - W'(1000);
      run_and_check("rand_div", OP_DIV, ra, rb, model(OP_DIV, ra, rb));
`endif
    end

`ifndef DIVIDER_SIGNED_EN
    // Signed opcode is just another ignored opcode in the default build
    start_op(OP_DIV, 32'd50, 32'd5);
    check_int("div_ignored_busy", int'(busy), 0);
    tick(2);
    check64("div_ignored_hold", dataOut, last_pub);
`endif

    // Protocol: DIVU and OUT mid-run are ignored
    start_op(OP_DIVU, 32'd1000, 32'd10);
    tick(5);
    start_op(OP_DIVU, 32'd50, 32'd5);
    check_int("midrun_divu_busy", int'(busy), 1);
    tick(5);
    publish();
    check64("midrun_out_hold", dataOut, last_pub);
    wait_done(lat);
    check_int("midrun_latency", lat, 20);
    check64("midrun_hold_at_done", dataOut, last_pub);
    publish();
    last_pub = model(OP_DIVU, 32'd1000, 32'd10);
    check64("midrun_result", dataOut, 64'h00000000_00000064);

    // OUT presented on the final-step edge is dropped
    start_op(OP_DIVU, 32'd77, 32'd5);
    tick(31);
    publish();
    check_int("final_edge_done", int'(done), 1);
    check64("final_edge_out_ignored", dataOut, last_pub);
    publish();
    last_pub = model(OP_DIVU, 32'd77, 32'd5);
    check64("final_edge_result", dataOut, 64'h00000002_0000000F);

    // Back-to-back: new DIVU accepted in the done cycle
    start_op(OP_DIVU, 32'd40, 32'd6);
    wait_done(lat);
    check_int("b2b_first_latency", lat, 32);
    start_op(OP_DIVU, 32'd81, 32'd9);
    check_int("b2b_second_busy", int'(busy), 1);
    wait_done(lat);
    check_int("b2b_second_latency", lat, 32);
    publish();
    last_pub = model(OP_DIVU, 32'd81, 32'd9);
    check64("b2b_result", dataOut, 64'h00000000_00000009);

    // Reset 10 cycles into a run aborts it and clears the published value
    start_op(OP_DIVU, 32'hDEADBEEF, 32'd7);
    tick(9);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    last_pub = '0;
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_done", int'(done), 0);
    check64("abort_dataOut", dataOut, '0);
    check_int("abort_state", int'(state_dbg), int'(IDLE));
    publish();
    check64("abort_result_cleared", dataOut, '0);
    run_and_check("after_reset_9_3", OP_DIVU, 32'd9, 32'd3, 64'h00000000_00000003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
